// File: rtl/pwm_dac_multi_if.sv
// Sample/control bundle between a sample source (master) and pwm_dac_multi (slave).
interface pwm_dac_multi_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int DIV_WIDTH  = 8
);
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]            data_valid;
    logic                         mode;
    logic [DIV_WIDTH-1:0]         div;
    logic [NUM_CH-1:0]            dac_out;
    logic                         dac_clk;
    logic                         period_start;

    modport master (
        output data_in, data_valid, mode, div,
        input  dac_out, dac_clk, period_start
    );

    modport slave (
        input  data_in, data_valid, mode, div,
        output dac_out, dac_clk, period_start
    );
endinterface

// File: rtl/pwm_dac_multi.sv
// Multi-channel double-buffered PWM / first-order sigma-delta DAC with a
// glitch-free programmable dac_clk divider. Samples are written into per-channel
// shadows at any time and committed to the modulators only at the period boundary.
module pwm_dac_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_dac_multi_if.slave dac_if
);
    localparam int N = DATA_WIDTH;
    localparam logic [N-1:0] CNT_MAX = '1;

    logic [N-1:0]          cnt_q;
    logic [N-1:0]          shadow_q [NUM_CH];
    logic [N-1:0]          active_q [NUM_CH];
    // Only the low N bits of the accumulator persist; the carry is consumed
    // combinationally as the output bit of the same step.
    logic [N-1:0]          acc_q    [NUM_CH];
    logic [N-1:0]          acc_d    [NUM_CH];
    logic [N:0]            sd_sum   [NUM_CH];
    logic [NUM_CH-1:0]     dac_out_q, dac_out_d;
    logic                  mode_sh_q, active_mode_q;
    logic [DIV_WIDTH-1:0]  dcnt_q, div_lat_q;
    logic                  dac_clk_q, period_start_q;
    logic                  swap, mode_change;

    assign swap        = (cnt_q == CNT_MAX);
    assign mode_change = swap && (mode_sh_q != active_mode_q);

    // One sigma-delta step: previous residue plus sample, carry out in bit N.
    function automatic logic [N:0] sd_step(input logic [N-1:0] residue, input logic [N-1:0] val);
        return {1'b0, residue} + {1'b0, val};
    endfunction

    // Shared period counter; boundary pulse lands in the cycle where cnt wraps to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_q + 1'b1;
            period_start_q <= swap;
        end
    end

    // Shadow capture on strobes; active samples take the old shadow at the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (dac_if.data_valid[i]) shadow_q[i] <= dac_if.data_in[i*N +: N];
                if (swap)                 active_q[i] <= shadow_q[i];
            end
        end
    end

    // Mode is shadowed every cycle and committed only at the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh_q     <= 1'b0;
            active_mode_q <= 1'b0;
        end else begin
            mode_sh_q <= dac_if.mode;
            if (swap) active_mode_q <= mode_sh_q;
        end
    end

    // Next output bit and accumulator residue per channel for the committed mode
    always_comb begin
        dac_out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sd_sum[i] = sd_step(acc_q[i], active_q[i]);
            acc_d[i]  = '0;
            if (active_mode_q) begin
                dac_out_d[i] = sd_sum[i][N];
                // A mode change restarts the modulator from a clean residue.
                acc_d[i]     = mode_change ? '0 : sd_sum[i][N-1:0];
            end else begin
                dac_out_d[i] = (cnt_q < active_q[i]);
            end
        end
    end

    // Register modulator residues and the output bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            dac_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
            dac_out_q <= dac_out_d;
        end
    end

    // dac_clk divider; a new divide value is latched only at a toggle so no runt pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            div_lat_q <= '0;
            dac_clk_q <= 1'b0;
        end else if (dcnt_q == div_lat_q) begin
            dac_clk_q <= ~dac_clk_q;
            dcnt_q    <= '0;
            div_lat_q <= dac_if.div;
        end else begin
            dcnt_q <= dcnt_q + 1'b1;
        end
    end

    assign dac_if.dac_out      = dac_out_q;
    assign dac_if.dac_clk      = dac_clk_q;
    assign dac_if.period_start = period_start_q;
endmodule
